// File: rtl/matmul_seq_pkg.sv
// matmul_pkg: shared types and constants for the matmul_seq sequencer.
//   - state_t        : sequencer FSM state encoding
//   - MAX_ELEMS_DFLT : default largest element count of any matrix
//   - AW_DFLT        : default element address width
//   - DIM_W          : width of each dimension input
//   - addr_calc      : x*y+z computed unsigned at 8 bits
package matmul_pkg;

    localparam int MAX_ELEMS_DFLT = 16;
    localparam int AW_DFLT        = 8;
    localparam int DIM_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CLEAR,
        ST_MAC,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    // Row-major address: always evaluated at 8 bits, callers resize to AW.
    function automatic logic [7:0] addr_calc(
        input logic [DIM_W-1:0] x,
        input logic [DIM_W-1:0] y,
        input logic [DIM_W-1:0] z
    );
        return 8'(x) * 8'(y) + 8'(z);
    endfunction

endpackage

// File: rtl/matmul_seq_if.sv
// matmul_seq_if: request/status and memory-strobe bundle of matmul_seq.
//   master : drives start, abort, r1, c1, r2, c2; observes everything else
//   slave  : the sequencer; drives busy, a_addr, b_addr, mac_clr, mac_en,
//            c_wr, c_addr, done, err
interface matmul_seq_if #(
    parameter int AW = matmul_pkg::AW_DFLT
);
    logic                          start;
    logic                          abort;
    logic [matmul_pkg::DIM_W-1:0]  r1;
    logic [matmul_pkg::DIM_W-1:0]  c1;
    logic [matmul_pkg::DIM_W-1:0]  r2;
    logic [matmul_pkg::DIM_W-1:0]  c2;
    logic                          busy;
    logic [AW-1:0]                 a_addr;
    logic [AW-1:0]                 b_addr;
    logic                          mac_clr;
    logic                          mac_en;
    logic                          c_wr;
    logic [AW-1:0]                 c_addr;
    logic                          done;
    logic                          err;

    modport master (
        output start, abort, r1, c1, r2, c2,
        input  busy, a_addr, b_addr, mac_clr, mac_en, c_wr, c_addr, done, err
    );

    modport slave (
        input  start, abort, r1, c1, r2, c2,
        output busy, a_addr, b_addr, mac_clr, mac_en, c_wr, c_addr, done, err
    );

endinterface

// File: rtl/matmul_seq_idx_gen.sv
// matmul_idx_gen: i/j/k loop counters and row-major address generation.
//   CLK, RST_N      : clock, synchronous active-low reset
//   zero            : clear i, j, k
//   step_k          : advance k (MAC cycle), wrapping after c1-1
//   step_j          : advance j (WRITE cycle), wrapping into i after c2-1
//   r1, c1, c2      : latched dimensions
//   last_i/j/k      : counter sits on its final value
//   a/b/c_addr      : i*c1+k, k*c2+j, i*c2+j resized to AW
module matmul_idx_gen
    import matmul_pkg::*;
#(
    parameter int AW = AW_DFLT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             zero,
    input  logic             step_k,
    input  logic             step_j,
    input  logic [DIM_W-1:0] r1,
    input  logic [DIM_W-1:0] c1,
    input  logic [DIM_W-1:0] c2,
    output logic             last_i,
    output logic             last_j,
    output logic             last_k,
    output logic [AW-1:0]    a_addr,
    output logic [AW-1:0]    b_addr,
    output logic [AW-1:0]    c_addr
);

    logic [DIM_W-1:0] i;
    logic [DIM_W-1:0] j;
    logic [DIM_W-1:0] k;

    assign last_i = (i == r1 - 1'b1);
    assign last_j = (j == c2 - 1'b1);
    assign last_k = (k == c1 - 1'b1);

    always_ff @(posedge CLK) begin
        if (!RST_N || zero) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            if (step_k) begin
                k <= last_k ? '0 : k + 1'b1;
            end
            if (step_j) begin
                if (last_j) begin
                    j <= '0;
                    i <= i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
        end
    end

    assign a_addr = AW'(addr_calc(i, c1, k));
    assign b_addr = AW'(addr_calc(k, c2, j));
    assign c_addr = AW'(addr_calc(i, c2, j));

endmodule

// File: rtl/matmul_seq.sv
// matmul_seq: sequencer for C = A x B over external element arrays and an
// external multiply-accumulator. One result element costs one clear cycle,
// c1 MAC cycles and one write cycle.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : matmul_seq_if.slave (request, dimensions, strobes, status)
//   cyc_cnt    : busy-cycle counter, present only with MATMUL_SEQ_PERF_EN
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for start, dimensions latched on start
// ST_CHECK | validate latched dimensions, zero i/j/k
// ST_CLEAR | mac_clr for the next result element
// ST_MAC   | mac_en, k walks 0..c1-1
// ST_WRITE | c_wr of element (i,j), advance j/i
// ST_DONE  | done pulse, success
// ST_ERR   | done pulse with err set, request rejected
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int MAX_ELEMS = MAX_ELEMS_DFLT,
    parameter int AW        = AW_DFLT
) (
    input  logic        CLK,
    input  logic        RST_N,
    matmul_seq_if.slave bus
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [15:0] cyc_cnt
`endif
);

    state_t           state;
    logic [DIM_W-1:0] r1_q;
    logic [DIM_W-1:0] c1_q;
    logic [DIM_W-1:0] r2_q;
    logic [DIM_W-1:0] c2_q;
    logic             last_i;
    logic             last_j;
    logic             last_k;
    logic [AW-1:0]    a_addr_w;
    logic [AW-1:0]    b_addr_w;
    logic [AW-1:0]    c_addr_w;
    logic [7:0]       n_a;
    logic [7:0]       n_b;
    logic [7:0]       n_c;
    logic             dims_bad;
    logic             accept;

    assign n_a = 8'(r1_q) * 8'(c1_q);
    assign n_b = 8'(r2_q) * 8'(c2_q);
    assign n_c = 8'(r1_q) * 8'(c2_q);

    assign dims_bad = (c1_q != r2_q)
                   || (r1_q == '0) || (c1_q == '0) || (r2_q == '0) || (c2_q == '0)
                   || (32'(n_a) > 32'(MAX_ELEMS))
                   || (32'(n_b) > 32'(MAX_ELEMS))
                   || (32'(n_c) > 32'(MAX_ELEMS));

    // abort in the same IDLE cycle drops the start
    assign accept = (state == ST_IDLE) && bus.start && !bus.abort;

    matmul_idx_gen #(.AW(AW)) u_idx (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .zero   (state == ST_CHECK),
        .step_k (state == ST_MAC),
        .step_j (state == ST_WRITE),
        .r1     (r1_q),
        .c1     (c1_q),
        .c2     (c2_q),
        .last_i (last_i),
        .last_j (last_j),
        .last_k (last_k),
        .a_addr (a_addr_w),
        .b_addr (b_addr_w),
        .c_addr (c_addr_w)
    );

    assign bus.a_addr = a_addr_w;
    assign bus.b_addr = b_addr_w;
    assign bus.c_addr = c_addr_w;

    // Strobes are registered for the state being entered, so each strobe is
    // high exactly while the FSM sits in the matching state.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            r1_q        <= '0;
            c1_q        <= '0;
            r2_q        <= '0;
            c2_q        <= '0;
            bus.busy    <= 1'b0;
            bus.mac_clr <= 1'b0;
            bus.mac_en  <= 1'b0;
            bus.c_wr    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.mac_clr <= 1'b0;
            bus.mac_en  <= 1'b0;
            bus.c_wr    <= 1'b0;
            bus.done    <= 1'b0;
            if (bus.abort && state != ST_IDLE) begin
                state    <= ST_IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            r1_q     <= bus.r1;
                            c1_q     <= bus.c1;
                            r2_q     <= bus.r2;
                            c2_q     <= bus.c2;
                            bus.err  <= 1'b0;
                            bus.busy <= 1'b1;
                            state    <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (dims_bad) begin
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                            state    <= ST_ERR;
                        end else begin
                            bus.mac_clr <= 1'b1;
                            state       <= ST_CLEAR;
                        end
                    end
                    ST_CLEAR: begin
                        bus.mac_en <= 1'b1;
                        state      <= ST_MAC;
                    end
                    ST_MAC: begin
                        if (last_k) begin
                            bus.c_wr <= 1'b1;
                            state    <= ST_WRITE;
                        end else begin
                            bus.mac_en <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        if (last_i && last_j) begin
                            bus.done <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            bus.mac_clr <= 1'b1;
                            state       <= ST_CLEAR;
                        end
                    end
                    ST_DONE, ST_ERR: begin
                        bus.busy <= 1'b0;
                        state    <= ST_IDLE;
                    end
                    default: begin
                        bus.busy <= 1'b0;
                        state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cyc_cnt <= '0;
        end else if (accept) begin
            cyc_cnt <= '0;
        end else if (bus.busy && cyc_cnt != 16'hFFFF) begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_seq.sv
module tb_matmul_seq;
    import matmul_pkg::*;

    localparam int MAXE = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_seq_if #(.AW(8)) bus();
`ifdef MATMUL_SEQ_PERF_EN
    logic [15:0] cyc_cnt;
`endif

    matmul_seq #(.MAX_ELEMS(MAXE), .AW(8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
`ifdef MATMUL_SEQ_PERF_EN
        ,
        .cyc_cnt (cyc_cnt)
`endif
    );

    typedef struct packed {
        logic       busy;
        logic       clr;
        logic       en;
        logic       wr;
        logic       done;
        logic       err;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } obs_t;

    obs_t exp_q[$];
    obs_t trace[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_on = 1'b0;
    bit   model_err = 1'b0;
    int   cyc_exp = 0;

    int         rec_cyc  = 0;
    int         done_cyc = -1;
    int         mac_n = 0;
    int         wr_n  = 0;
    logic [7:0] a_log[$];
    logic [7:0] b_log[$];
    logic [7:0] c_log[$];
    logic       busy_log[$];
    logic       err_log[$];

    // Expected cycle-by-cycle view of one request, starting with the cycle
    // after start was sampled, ending with the done cycle.
    function automatic void build_trace(input int r1, input int c1, input int r2, input int c2);
        obs_t e;
        bit   ok;
        ok = (c1 == r2) && r1 > 0 && c1 > 0 && r2 > 0 && c2 > 0
          && r1 * c1 <= MAXE && r2 * c2 <= MAXE && r1 * c2 <= MAXE;
        trace.delete();
        e = '0; e.busy = 1'b1;
        trace.push_back(e);
        if (!ok) begin
            e = '0; e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1;
            trace.push_back(e);
            return;
        end
        for (int i = 0; i < r1; i++) begin
            for (int j = 0; j < c2; j++) begin
                e = '0; e.busy = 1'b1; e.clr = 1'b1;
                trace.push_back(e);
                for (int k = 0; k < c1; k++) begin
                    e = '0; e.busy = 1'b1; e.en = 1'b1;
                    e.a = 8'((i * c1 + k) % 256);
                    e.b = 8'((k * c2 + j) % 256);
                    trace.push_back(e);
                end
                e = '0; e.busy = 1'b1; e.wr = 1'b1;
                e.c = 8'((i * c2 + j) % 256);
                trace.push_back(e);
            end
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1;
        trace.push_back(e);
    endfunction

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // Single compare process: every cycle against the model queue, or
    // against the idle expectation when no request is in flight.
    always @(negedge clk) begin
        if (mon_on) begin
            obs_t e;
            obs_t act;
            bit   idle;
            idle = (exp_q.size() == 0);
            if (!idle) begin
                e = exp_q.pop_front();
            end else begin
                e = '0;
                e.err = model_err;
            end
            act.busy = bus.busy;  act.clr = bus.mac_clr; act.en = bus.mac_en;
            act.wr = bus.c_wr;    act.done = bus.done;   act.err = bus.err;
            act.a = bus.a_addr;   act.b = bus.b_addr;    act.c = bus.c_addr;
            total++;
            if (act.busy !== e.busy || act.clr !== e.clr || act.en !== e.en ||
                act.wr !== e.wr || act.done !== e.done || act.err !== e.err ||
                (e.en && (act.a !== e.a || act.b !== e.b)) || (e.wr && act.c !== e.c)) begin
                bad++;
                $display("FAIL cycle_check t=%0t got b%0b clr%0b en%0b wr%0b dn%0b er%0b a%0d b%0d c%0d want b%0b clr%0b en%0b wr%0b dn%0b er%0b a%0d b%0d c%0d",
                         $time, act.busy, act.clr, act.en, act.wr, act.done, act.err, act.a, act.b, act.c,
                         e.busy, e.clr, e.en, e.wr, e.done, e.err, e.a, e.b, e.c);
            end
`ifdef MATMUL_SEQ_PERF_EN
            if (idle) begin
                total++;
                if (cyc_cnt !== 16'(cyc_exp)) begin
                    bad++;
                    $display("FAIL cyc_cnt t=%0t got=%0d want=%0d", $time, cyc_cnt, cyc_exp);
                end
            end
`endif
            rec_cyc++;
            busy_log.push_back(act.busy);
            err_log.push_back(act.err);
            if (act.done && done_cyc < 0) done_cyc = rec_cyc;
            if (act.en) begin mac_n++; a_log.push_back(act.a); b_log.push_back(act.b); end
            if (act.wr) begin wr_n++; c_log.push_back(act.c); end
        end
    end

    task automatic drive_rand_dims();
        bus.r1 = 4'($urandom_range(0, 15));
        bus.c1 = 4'($urandom_range(0, 15));
        bus.r2 = 4'($urandom_range(0, 15));
        bus.c2 = 4'($urandom_range(0, 15));
    endtask

    task automatic idle_cycles(input int n);
        for (int t = 0; t < n; t++) begin
            drive_rand_dims();
            @(posedge clk); #1;
        end
    endtask

    // kill_kind: 0 none, 1 abort, 2 reset, applied in cycle kill_t.
    // st_t: cycle of an extra start pulse while busy; -1 random start noise.
    task automatic run_op(input int r1, input int c1, input int r2, input int c2,
                          input int kill_t, input int kill_kind, input int st_t);
        int len;
        build_trace(r1, c1, r2, c2);
        if (kill_t > trace.size()) kill_t = 0;
        if (kill_t > 0) begin
            while (trace.size() > kill_t) void'(trace.pop_back());
        end
        bus.start = 1'b1; bus.abort = 1'b0;
        bus.r1 = 4'(r1); bus.c1 = 4'(c1); bus.r2 = 4'(r2); bus.c2 = 4'(c2);
        @(posedge clk); #1;
        rec_cyc = 0; done_cyc = -1; mac_n = 0; wr_n = 0;
        a_log.delete(); b_log.delete(); c_log.delete(); busy_log.delete(); err_log.delete();
        foreach (trace[n]) exp_q.push_back(trace[n]);
        model_err = trace[trace.size() - 1].err;
        cyc_exp = trace.size();
        len = trace.size();
        for (int t = 1; t <= len; t++) begin
            bus.start = (st_t < 0) ? 1'($urandom_range(0, 1)) : (t == st_t);
            bus.abort = (kill_kind == 1 && t == kill_t);
            rst_n = !(kill_kind == 2 && t == kill_t);
            drive_rand_dims();
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.abort = 1'b0; rst_n = 1'b1;
        if (kill_kind == 2 && kill_t > 0) begin
            exp_q.delete(); model_err = 1'b0; cyc_exp = 0;
        end
        idle_cycles(2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.r1 = '0; bus.c1 = '0; bus.r2 = '0; bus.c2 = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        @(posedge clk); #1;
        chk("rst_a_addr", bus.a_addr, 0);
        chk("rst_c_addr", bus.c_addr, 0);
        rst_n = 1'b1;
        idle_cycles(2);

        build_trace(2, 2, 2, 2);
        chk("model_len_2x2", trace.size(), 18);
        build_trace(1, 3, 3, 1);
        chk("model_len_1x3", trace.size(), 7);

        run_op(2, 2, 2, 2, 0, 0, 0);
        chk("2x2_done_cyc", done_cyc, 18);
        chk("2x2_mac_n", mac_n, 8);
        chk("2x2_wr_n", wr_n, 4);
        chk("2x2_c_n", c_log.size(), 4);
        for (int n = 0; n < c_log.size(); n++) chk("2x2_c_addr", c_log[n], n);
        chk("2x2_err", bus.err, 0);
`ifdef MATMUL_SEQ_PERF_EN
        chk("2x2_cyc_cnt", cyc_cnt, 18);
        idle_cycles(3);
        chk("2x2_cyc_hold", cyc_cnt, 18);
`endif

        run_op(1, 3, 3, 1, 0, 0, 0);
        chk("1x3_done_cyc", done_cyc, 7);
        chk("1x3_a_n", a_log.size(), 3);
        for (int n = 0; n < a_log.size(); n++) chk("1x3_a_addr", a_log[n], n);
        for (int n = 0; n < b_log.size(); n++) chk("1x3_b_addr", b_log[n], n);
        chk("1x3_wr_n", wr_n, 1);
        chk("1x3_c_addr", (c_log.size() > 0) ? c_log[0] : 8'hFF, 0);

        run_op(2, 3, 2, 2, 0, 0, 0);
        chk("mism_done_cyc", done_cyc, 2);
        chk("mism_err_at_done", (err_log.size() > 1) ? err_log[1] : 1'bx, 1);
        chk("mism_strobes", mac_n + wr_n, 0);
        idle_cycles(3);
        chk("mism_err_held", bus.err, 1);
        run_op(1, 1, 1, 1, 0, 0, 0);
        chk("err_clear_in_check", (err_log.size() > 0) ? err_log[0] : 1'bx, 0);

        run_op(5, 4, 4, 1, 0, 0, 0);
        chk("big_done_cyc", done_cyc, 2);
        chk("big_err", bus.err, 1);
        run_op(2, 0, 0, 2, 0, 0, 0);
        chk("zero_done_cyc", done_cyc, 2);
        chk("zero_strobes", mac_n + wr_n, 0);

        // reset in idle clears a pending err
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_err = 1'b0; cyc_exp = 0; rst_n = 1'b1;
        idle_cycles(1);
        chk("rst_err", bus.err, 0);

        run_op(2, 2, 2, 2, 6, 1, 5);
        chk("abort_busy_c7", (busy_log.size() > 6) ? busy_log[6] : 1'bx, 0);
        chk("abort_no_done", done_cyc, -1);

        run_op(2, 2, 2, 2, 4, 2, 0);
        chk("midrst_a_addr", bus.a_addr, 0);
        chk("midrst_b_addr", bus.b_addr, 0);
        chk("midrst_busy", bus.busy, 0);

        bus.start = 1'b1; bus.abort = 1'b1;
        bus.r1 = 4'd1; bus.c1 = 4'd1; bus.r2 = 4'd1; bus.c2 = 4'd1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        idle_cycles(1);
        chk("abort_start_idle", bus.busy, 0);

        for (int n = 0; n < 80; n++) begin
            int r1, c1, r2, c2, kind, kt;
            r1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
            c1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
            c2 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
            r2 = ($urandom_range(0, 3) != 0) ? c1 : $urandom_range(0, 15);
            kind = $urandom_range(0, 9);
            kind = (kind == 0) ? 1 : (kind == 1) ? 2 : 0;
            kt = (kind != 0) ? $urandom_range(1, 20) : 0;
            run_op(r1, c1, r2, c2, kt, kind, ($urandom_range(0, 1) == 0) ? -1 : 0);
        end

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
